bus_initiator: RTL and testbench

- Avalon-style bus master that sits between the CPU core's memory-access stage and bus_memory (or any slave with the same address/byteenable/read/write/waitrequest/readdata interface).
- Accepts one CPU request at a time through a valid/ready handshake and drives it onto the bus.
- Holds bus signals stable while waitrequest is high and captures read data after a fixed read latency.
- Returns one response per request, flagged with an error bit on timeout or on an illegal request.

---
 rtl/bus_initiator_pkg.sv | 23 ++
 rtl/bus_initiator_if.sv | 45 ++++
 rtl/bus_wait_timer.sv | 38 +++
 rtl/bus_initiator.sv | 146 ++++++++++++++
 tb/tb_bus_initiator.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_initiator_pkg.sv
// Shared types and bus geometry for the bus initiator.
// Imported by the interface, the timer and the top.
package bus_initiator_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_BE_W   = 4;

  localparam logic [BUS_ADDR_W-1:0] INSTRUCTION_START = 32'hBFC00000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DATA
  } state_e;

  function automatic logic [BUS_ADDR_W-1:0] word_align(
    input logic [BUS_ADDR_W-1:0] a
  );
    return {a[BUS_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/bus_initiator_if.sv
// CPU request/response handshake plus Avalon-style bus signals.
// master = initiator view, slave = CPU and bus slave view.
interface bus_initiator_if;
  import bus_initiator_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [BUS_ADDR_W-1:0] req_addr;
  logic [BUS_BE_W-1:0]   req_byteenable;
  logic [BUS_DATA_W-1:0] req_wdata;

  logic                  resp_valid;
  logic [BUS_DATA_W-1:0] resp_rdata;
  logic                  resp_error;

  logic [BUS_ADDR_W-1:0] address;
  logic [BUS_BE_W-1:0]   byteenable;
  logic [BUS_DATA_W-1:0] writedata;
  logic                  write;
  logic                  read;
  logic                  waitrequest;
  logic [BUS_DATA_W-1:0] readdata;

  modport master (
    input  req_valid, req_write, req_addr,
    input  req_byteenable, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_error,
    output address, byteenable, writedata,
    output write, read,
    input  waitrequest, readdata
  );

  modport slave (
    output req_valid, req_write, req_addr,
    output req_byteenable, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_error,
    input  address, byteenable, writedata,
    input  write, read,
    output waitrequest, readdata
  );

endinterface

// File: rtl/bus_wait_timer.sv
// Loadable down-counter with clear; tc flags the last count.
// Load wins over clear, clear wins over decrement.
module bus_wait_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (clr) begin
      cnt_d = '0;
    end else if (dec && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == W'(1));

endmodule

// File: rtl/bus_initiator.sv
// Single-outstanding Avalon-style bus master for the MEM stage.
// One response per request; error on timeout or empty byteenable.
module bus_initiator
  import bus_initiator_pkg::*;
#(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic             clk,
  input logic             reset_n,
  bus_initiator_if.master bif
);

  localparam int TMO_W = 16;
  localparam int LAT_W = 3;

  state_e                state_q, state_d;
  logic [BUS_ADDR_W-1:0] addr_q, addr_d;
  logic [BUS_BE_W-1:0]   be_q, be_d;
  logic [BUS_DATA_W-1:0] wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic                  rv_q, rv_d;
  logic                  rerr_q, rerr_d;
  logic [BUS_DATA_W-1:0] rdata_q, rdata_d;

  logic tmo_load, tmo_dec, tmo_tc;
  logic lat_load, lat_dec, lat_tc;
  logic tmr_clr;

  assign tmr_clr = (state_q == IDLE);

  bus_wait_timer #(.W(TMO_W)) u_tmo (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (tmr_clr),
    .load     (tmo_load),
    .load_val (TMO_W'(TIMEOUT_CYCLES)),
    .dec      (tmo_dec),
    .tc       (tmo_tc)
  );

  bus_wait_timer #(.W(LAT_W)) u_lat (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (tmr_clr),
    .load     (lat_load),
    .load_val (LAT_W'(READ_LATENCY)),
    .dec      (lat_dec),
    .tc       (lat_tc)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    rv_d     = 1'b0;
    rerr_d   = 1'b0;
    rdata_d  = '0;
    tmo_load = 1'b0;
    tmo_dec  = 1'b0;
    lat_load = 1'b0;
    lat_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bif.req_valid) begin
          if (bif.req_byteenable == '0) begin
            rv_d   = 1'b1;
            rerr_d = 1'b1;
          end else begin
            addr_d   = word_align(bif.req_addr);
            be_d     = bif.req_byteenable;
            wdata_d  = bif.req_wdata;
            wr_d     = bif.req_write;
            tmo_load = 1'b1;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        unique case (1'b1)
          !bif.waitrequest && wr_q: begin
            rv_d    = 1'b1;
            state_d = IDLE;
          end
          !bif.waitrequest && !wr_q: begin
            lat_load = 1'b1;
            state_d  = WAIT_DATA;
          end
          bif.waitrequest && tmo_tc: begin
            rv_d    = 1'b1;
            rerr_d  = 1'b1;
            state_d = IDLE;
          end
          default: tmo_dec = 1'b1;
        endcase
      end
      WAIT_DATA: begin
        // tc marks the cycle whose closing edge carries readdata
        if (lat_tc) begin
          rv_d    = 1'b1;
          rdata_d = bif.readdata;
          state_d = IDLE;
        end else begin
          lat_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rv_q    <= 1'b0;
      rerr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rv_q    <= rv_d;
      rerr_q  <= rerr_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes decode straight from state so reset drops them at once
  assign bif.req_ready  = reset_n && (state_q == IDLE);
  assign bif.read       = (state_q == ISSUE) && !wr_q;
  assign bif.write      = (state_q == ISSUE) && wr_q;
  assign bif.address    = addr_q;
  assign bif.byteenable = be_q;
  assign bif.writedata  = wdata_q;
  assign bif.resp_valid = rv_q;
  assign bif.resp_error = rerr_q;
  assign bif.resp_rdata = rdata_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench: a per-cycle timeline model built from a request
// table, compared every cycle, plus literal pins and a reset test.
module tb_bus_initiator;

  localparam int T  = 4;
  localparam int L  = 1;
  localparam int NV = 10;
  localparam int NC = 48;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  bus_initiator_if bif();

  bus_initiator #(
    .READ_LATENCY   (L),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bif     (bif.master)
  );

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          stall;
    logic [31:0] rdata;
    int          gap;
  } vec_t;

  vec_t v [NV];

  logic        i_valid [NC];
  logic        i_write [NC];
  logic [31:0] i_addr  [NC];
  logic [3:0]  i_be    [NC];
  logic [31:0] i_wdata [NC];
  logic        i_wait  [NC];
  logic [31:0] i_rdata [NC];

  logic        e_rdy   [NC];
  logic        e_read  [NC];
  logic        e_write [NC];
  logic        e_bus   [NC];
  logic [31:0] e_addr  [NC];
  logic [3:0]  e_be    [NC];
  logic [31:0] e_wdata [NC];
  logic        e_rv    [NC];
  logic        e_err   [NC];
  logic [31:0] e_rdata [NC];

  logic        o_read  [NC];
  logic        o_write [NC];
  logic        o_rv    [NC];
  logic        o_err   [NC];
  logic [31:0] o_addr  [NC];
  logic [3:0]  o_be    [NC];
  logic [31:0] o_rdata [NC];

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string nm, input int c,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, act, exp);
    end
  endtask

  // Timeline of one request accepted in cycle s:
  // strobe for n cycles, response after write/timeout or latency
  task automatic build();
    int  s, r, n;
    bit  to;
    for (int c = 0; c < NC; c++) begin
      i_valid[c] = 1'b0;
      i_write[c] = 1'($urandom);
      i_addr[c]  = $urandom;
      i_be[c]    = 4'($urandom);
      i_wdata[c] = $urandom;
      i_wait[c]  = 1'b1;
      i_rdata[c] = $urandom;
      e_rdy[c]   = 1'b1;
      e_read[c]  = 1'b0;
      e_write[c] = 1'b0;
      e_bus[c]   = 1'b0;
      e_addr[c]  = '0;
      e_be[c]    = '0;
      e_wdata[c] = '0;
      e_rv[c]    = 1'b0;
      e_err[c]   = 1'b0;
      e_rdata[c] = '0;
    end
    s = 1;
    for (int k = 0; k < NV; k++) begin
      i_valid[s] = 1'b1;
      i_write[s] = v[k].w;
      i_addr[s]  = v[k].addr;
      i_be[s]    = v[k].be;
      i_wdata[s] = v[k].wdata;
      if (v[k].be == 4'h0) begin
        r = s + 1;
        e_err[r] = 1'b1;
      end else begin
        to = (v[k].stall >= T);
        n  = to ? T : v[k].stall + 1;
        for (int j = 1; j <= n; j++) begin
          e_read[s+j]  = !v[k].w;
          e_write[s+j] = v[k].w;
          e_bus[s+j]   = 1'b1;
          e_addr[s+j]  = v[k].addr & ~32'd3;
          e_be[s+j]    = v[k].be;
          e_wdata[s+j] = v[k].wdata;
        end
        if (to) begin
          r = s + n + 1;
          e_err[r] = 1'b1;
        end else begin
          i_wait[s+n] = 1'b0;
          if (v[k].w) begin
            r = s + n + 1;
          end else begin
            i_rdata[s+n+L] = v[k].rdata;
            r = s + n + L + 1;
            e_rdata[r] = v[k].rdata;
          end
        end
        for (int j = s + 1; j < r; j++) e_rdy[j] = 1'b0;
      end
      e_rv[r] = 1'b1;
      s = r + v[k].gap;
    end
  endtask

  initial begin
    int cnt;
    v[0] = '{1'b0, 32'hBFC00004, 4'hF, 32'h0, 0, 32'hDEADBEEF, 1};
    v[1] = '{1'b1, 32'hBFC00013, 4'h3, 32'h12345678, 3, 32'h0, 1};
    v[2] = '{1'b0, 32'hBFC00020, 4'hF, 32'h0, 10, 32'h0, 1};
    v[3] = '{1'b0, 32'hBFC00026, 4'hC, 32'h0, 1, 32'h0BADF00D, 1};
    v[4] = '{1'b1, 32'h00000050, 4'h0, 32'h77, 0, 32'h0, 1};
    v[5] = '{1'b0, 32'h00000100, 4'hF, 32'h0, 0, 32'h11112222, 0};
    v[6] = '{1'b1, 32'h00000205, 4'h8, 32'hCAFEF00D, 0, 32'h0, 0};
    v[7] = '{1'b0, 32'h00000030, 4'h6, 32'h0, 2, 32'h55AA55AA, 2};
    v[8] = '{1'b0, 32'h00000060, 4'h0, 32'h0, 0, 32'h0, 0};
    v[9] = '{1'b1, 32'h00000404, 4'hF, 32'hA5A5A5A5, 4, 32'h0, 1};
    build();

    reset_n = 1'b1;
    bif.req_valid      = 1'b0;
    bif.req_write      = 1'b0;
    bif.req_addr       = '0;
    bif.req_byteenable = '0;
    bif.req_wdata      = '0;
    bif.waitrequest    = 1'b0;
    bif.readdata       = '0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read",   0, bif.read, 1'b0);
    chk("rst_write",  0, bif.write, 1'b0);
    chk("rst_rv",     0, bif.resp_valid, 1'b0);
    chk("rst_err",    0, bif.resp_error, 1'b0);
    chk("rst_ready",  0, bif.req_ready, 1'b0);
    chk("rst_addr",   0, bif.address, 32'h0);
    chk("rst_be",     0, bif.byteenable, 4'h0);
    chk("rst_wdata",  0, bif.writedata, 32'h0);
    chk("rst_rdata",  0, bif.resp_rdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int c = 0; c < NC; c++) begin
      @(posedge clk);
      #1;
      bif.req_valid      = i_valid[c];
      bif.req_write      = i_write[c];
      bif.req_addr       = i_addr[c];
      bif.req_byteenable = i_be[c];
      bif.req_wdata      = i_wdata[c];
      bif.waitrequest    = i_wait[c];
      bif.readdata       = i_rdata[c];
      @(negedge clk);
      o_read[c]  = bif.read;
      o_write[c] = bif.write;
      o_rv[c]    = bif.resp_valid;
      o_err[c]   = bif.resp_error;
      o_addr[c]  = bif.address;
      o_be[c]    = bif.byteenable;
      o_rdata[c] = bif.resp_rdata;
      chk("req_ready",  c, bif.req_ready, e_rdy[c]);
      chk("read",       c, bif.read, e_read[c]);
      chk("write",      c, bif.write, e_write[c]);
      chk("resp_valid", c, bif.resp_valid, e_rv[c]);
      if (e_rv[c]) begin
        chk("resp_error", c, bif.resp_error, e_err[c]);
        chk("resp_rdata", c, bif.resp_rdata, e_rdata[c]);
      end
      if (e_bus[c]) begin
        chk("address",    c, bif.address, e_addr[c]);
        chk("byteenable", c, bif.byteenable, e_be[c]);
        chk("writedata",  c, bif.writedata, e_wdata[c]);
      end
    end

    chk("lit_rd_addr",   2, o_addr[2], 32'hBFC00004);
    chk("lit_rd_strobe", 2, {o_read[2], o_read[3]}, 2'b10);
    chk("lit_rd_resp",   4, {o_rv[3], o_rv[4], o_err[4]}, 3'b010);
    chk("lit_rd_data",   4, o_rdata[4], 32'hDEADBEEF);
    chk("lit_wr_addr",   6, o_addr[6], 32'hBFC00010);
    chk("lit_wr_be",     6, o_be[6], 4'h3);
    cnt = 0;
    for (int c = 5; c <= 10; c++) cnt += int'(o_write[c]);
    chk("lit_wr_hold",   10, cnt, 4);
    chk("lit_wr_resp",   10, {o_rv[10], o_err[10]}, 2'b10);
    cnt = 0;
    for (int c = 11; c <= 16; c++) cnt += int'(o_read[c]);
    chk("lit_tmo_len",   16, cnt, 4);
    chk("lit_tmo_resp",  16, {o_read[16], o_rv[16], o_err[16]}, 3'b011);
    chk("lit_tmo_rdata", 16, o_rdata[16], 32'h0);
    cnt = 0;
    for (int c = 22; c <= 24; c++) cnt += int'(o_read[c] | o_write[c]);
    chk("lit_ill_bus",   23, cnt, 0);
    chk("lit_ill_resp",  23, {o_rv[23], o_err[23]}, 2'b11);
    cnt = 0;
    for (int c = 0; c < NC; c++) cnt += int'(o_rv[c]);
    chk("lit_resp_count", NC, cnt, NV);

    @(posedge clk);
    #1;
    bif.req_valid      = 1'b1;
    bif.req_write      = 1'b0;
    bif.req_addr       = 32'h00000040;
    bif.req_byteenable = 4'hF;
    bif.waitrequest    = 1'b1;
    @(posedge clk);
    #1;
    bif.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_read", 0, bif.read, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_read",  0, bif.read, 1'b0);
    chk("mid_rst_write", 0, bif.write, 1'b0);
    chk("mid_rst_ready", 0, bif.req_ready, 1'b0);
    chk("mid_rst_addr",  0, bif.address, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", 0, bif.req_ready, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("post_rst_rv",   c, bif.resp_valid, 1'b0);
      chk("post_rst_read", c, bif.read, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
